ioctl_rom_loader: RTL and testbench

//  Sits between data_io and the sdram controller. Takes the ioctl byte stream

---
 rtl/ioctl_rom_loader.sv | 132 +++++++++++++
 tb/tb_ioctl_rom_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_loader.sv
// rtl/ioctl_rom_loader.sv - buffers ioctl ROM download bytes into toggle req/ack sdram writes
module ioctl_rom_loader #(
    parameter int         AW         = 23,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ROM_INDEX  = 8'd0,
    parameter int         RESET_HOLD = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          port_req,
    input  logic          port_ack,
    output logic [AW-1:0] port_a,
    output logic [1:0]    port_ds,
    output logic          port_we,
    output logic [15:0]   port_d,
    input  logic          ext_reset,
    output logic          busy,
    output logic          overflow,
    output logic          rom_loaded,
    output logic          core_reset
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = AW + 1 + 8;
    localparam int HW = $clog2(RESET_HOLD + 1);

    typedef enum logic [1:0] {SYNC, IDLE, WAIT} state_t;
    state_t state, state_nx;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [HW-1:0] hold;
    logic          wr_d, dl_d, rom_dl, done;
    logic          rom_sel, empty, full, push, do_write, issue, pop;
    logic          dl_rise, dl_fall, load;
    wire           unused_ok = &{1'b0, ioctl_addr};

    assign rom_sel  = (ioctl_index == ROM_INDEX);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign push     = ioctl_wr & ~wr_d & ioctl_download & rom_sel;
    assign do_write = push & (~full | pop);
    assign head     = fifo_mem[rd_ptr[PW-1:0]];
    assign dl_rise  = ioctl_download & ~dl_d & rom_sel;
    assign dl_fall  = ~ioctl_download & dl_d & rom_dl;
    assign load     = done & empty & (state == IDLE);

    assign busy       = ~empty | (state == WAIT);
    assign core_reset = ext_reset | ~rom_loaded | (hold != '0);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        pop      = 1'b0;
        case (state)
            SYNC: state_nx = IDLE;
            IDLE: if (!empty) begin
                issue    = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (port_req == port_ack) begin
                pop      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = SYNC;
        endcase
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (do_write) fifo_mem[wr_ptr[PW-1:0]] <= {ioctl_addr[AW:0], ioctl_dout};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SYNC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_d       <= 1'b0;
            dl_d       <= 1'b0;
            rom_dl     <= 1'b0;
            done       <= 1'b0;
            hold       <= '0;
            port_req   <= 1'b0;
            port_we    <= 1'b0;
            port_a     <= '0;
            port_ds    <= '0;
            port_d     <= '0;
            overflow   <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            state <= state_nx;
            wr_d  <= ioctl_wr;
            dl_d  <= ioctl_download;
            if (do_write) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)      rd_ptr <= rd_ptr + (PW+1)'(1);

            // Align the toggle pair so a stale ack level never looks like a completion.
            if (state == SYNC) port_req <= port_ack;
            if (issue) begin
                port_req <= ~port_req;
                port_we  <= 1'b1;
                port_a   <= head[EW-1:9];
                port_ds  <= {head[8], ~head[8]};
                port_d   <= {head[7:0], head[7:0]};
            end
            if (pop) port_we <= 1'b0;

            if (push && full && !pop) overflow <= 1'b1;
            if (dl_rise) begin
                rom_dl     <= 1'b1;
                done       <= 1'b0;
                overflow   <= 1'b0;
                rom_loaded <= 1'b0;
            end else if (dl_fall) begin
                rom_dl <= 1'b0;
                done   <= 1'b1;
            end else if (load) begin
                done       <= 1'b0;
                rom_loaded <= 1'b1;
            end

            if (load && !dl_rise) hold <= HW'(RESET_HOLD);
            else if (hold != '0)  hold <= hold - HW'(1);
        end
    end
endmodule

// File: tb/tb_ioctl_rom_loader.sv
// tb/tb_ioctl_rom_loader.sv - self-checking bench for ioctl_rom_loader
module tb_ioctl_rom_loader;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        port_ack = 1'b1;
    logic        ext_reset = 1'b0;
    logic        port_req, port_we, busy, overflow, rom_loaded, core_reset;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;

    ioctl_rom_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .port_req(port_req), .port_ack(port_ack),
        .port_a(port_a), .port_ds(port_ds), .port_we(port_we), .port_d(port_d),
        .ext_reset(ext_reset), .busy(busy), .overflow(overflow),
        .rom_loaded(rom_loaded), .core_reset(core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
        logic        we;
    } wr_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        wr_t         exp;
    } vec_t;

    int  checks = 0;
    int  failures = 0;
    wr_t got[$];
    int  ack_delay = 3;
    int  ack_count = 0;
    int  unstable = 0;
    bit  armed = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Reference: each accepted byte becomes one word write, addressed by byte address / 2.
    function automatic wr_t model(logic [24:0] addr, logic [7:0] b);
        wr_t w;
        w.a  = 23'((addr % 25'h1000000) / 2);
        w.ds = (addr % 2 == 1) ? 2'b10 : 2'b01;
        w.d  = {b, b};
        w.we = 1'b1;
        return w;
    endfunction

    // Sdram side: captures each new request and toggles ack after ack_delay cycles.
    initial begin
        bit   pending = 0;
        int   cnt = 0;
        logic last_req = 1'b0;
        wr_t  cur;
        forever begin
            @(negedge clk_sys);
            if (!armed || !reset_n) begin
                pending  = 0;
                last_req = port_req;
            end else if (pending) begin
                if ({port_a, port_ds, port_d, port_we} !== {cur.a, cur.ds, cur.d, 1'b1}) unstable++;
                if (cnt == 0) begin
                    port_ack = last_req;
                    pending  = 0;
                    ack_count++;
                end else cnt--;
            end else if (port_req !== last_req) begin
                cur = '{port_a, port_ds, port_d, port_we};
                got.push_back(cur);
                last_req = port_req;
                pending  = 1;
                cnt      = ack_delay;
            end
        end
    end

    task automatic write_byte(logic [24:0] addr, logic [7:0] data, int hold, int gap);
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        cyc(hold);
        ioctl_wr   = 1'b0;
        cyc(gap);
    endtask

    task automatic dl_start(logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        cyc(2);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        cyc(1);
        while (busy && n < 500) begin cyc(1); n++; end
        check(name, busy, 0);
    endtask

    task automatic wait_loaded(string name);
        int n = 0;
        while (!rom_loaded && n < 500) begin cyc(1); n++; end
        check(name, rom_loaded, 1);
    endtask

    task automatic compare_q(string name, wr_t exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", name, i), got[i], exp[i]);
    endtask

    initial begin
        vec_t        tbl[6];
        wr_t         exp[$];
        logic [24:0] ra;
        logic [7:0]  rd;
        logic        req_before;
        int          base, n;
        bit          early;

        tbl[0] = '{25'h0000000, 8'hAA, '{23'h000000, 2'b01, 16'hAAAA, 1'b1}};
        tbl[1] = '{25'h0000001, 8'hBB, '{23'h000000, 2'b10, 16'hBBBB, 1'b1}};
        tbl[2] = '{25'h0000002, 8'hCC, '{23'h000001, 2'b01, 16'hCCCC, 1'b1}};
        tbl[3] = '{25'h0000003, 8'hDD, '{23'h000001, 2'b10, 16'hDDDD, 1'b1}};
        tbl[4] = '{25'h1FFFFFF, 8'h5A, '{23'h7FFFFF, 2'b10, 16'h5A5A, 1'b1}};
        tbl[5] = '{25'h0000101, 8'h01, '{23'h000080, 2'b10, 16'h0101, 1'b1}};

        // Reset values with ack parked high, then SYNC alignment
        cyc(2);
        check("rst_req", port_req, 0);
        check("rst_we", port_we, 0);
        check("rst_a_ds_d", {port_a, port_ds, port_d}, 0);
        check("rst_flags", {busy, overflow, rom_loaded, core_reset}, 4'b0001);
        reset_n = 1'b1;
        cyc(2);
        check("sync_req", port_req, 1);
        check("sync_no_write", got.size(), 0);
        check("sync_core_reset", core_reset, 1);
        armed = 1;
        cyc(1);

        // Table-driven writes, ack 3 cycles after each request
        ack_delay = 3;
        dl_start(8'h00);
        foreach (tbl[i]) write_byte(tbl[i].addr, tbl[i].data, 2, 10);
        wait_idle("tbl_drain");
        exp.delete();
        foreach (tbl[i]) exp.push_back(tbl[i].exp);
        compare_q("tbl", exp);
        ioctl_download = 1'b0;
        wait_loaded("tbl_loaded");
        cyc(20);
        check("tbl_core_reset_low", core_reset, 0);

        // Back-to-back bytes with a slow ack: FIFO fills, the last two are dropped
        ack_delay = 40;
        got.delete();
        dl_start(8'h00);
        check("ovf_start_loaded", {rom_loaded, core_reset}, 2'b01);
        exp.delete();
        for (int i = 0; i < 6; i++) begin
            write_byte(25'h100 + 25'(i), 8'h10 + 8'(i), 1, 1);
            if (i < 4) exp.push_back(model(25'h100 + 25'(i), 8'h10 + 8'(i)));
        end
        cyc(1);
        check("ovf_set", overflow, 1);
        wait_idle("ovf_drain");
        compare_q("ovf", exp);
        check("ovf_sticky", overflow, 1);
        ioctl_download = 1'b0;
        wait_loaded("ovf_loaded");
        dl_start(8'h00);
        check("ovf_cleared", overflow, 0);

        // Download ends with two bytes still queued
        ack_delay = 10;
        got.delete();
        base = ack_count;
        write_byte(25'h200, 8'h77, 1, 1);
        write_byte(25'h201, 8'h88, 1, 0);
        ioctl_download = 1'b0;
        n = 0;
        early = 0;
        while (!rom_loaded && n < 300) begin
            cyc(1);
            n++;
            if (rom_loaded && (ack_count - base) < 2) early = 1;
        end
        check("q_loaded", rom_loaded, 1);
        check("q_after_2nd_ack", {early, 32'(ack_count - base)}, {1'b0, 32'd2});
        n = 0;
        while (core_reset && n < 100) begin cyc(1); n++; end
        check("q_hold_cycles", n, 16);

        // Foreign index is ignored
        got.delete();
        req_before = port_req;
        dl_start(8'hFF);
        for (int i = 0; i < 3; i++) write_byte(25'h300 + 25'(i), 8'hE0, 1, 2);
        ioctl_download = 1'b0;
        cyc(10);
        ioctl_index = 8'h00;
        check("ff_no_req", {port_req, 32'(got.size())}, {req_before, 32'd0});
        check("ff_state", {rom_loaded, busy, core_reset}, 3'b100);

        // External reset forces core_reset
        ext_reset = 1'b1;
        cyc(1);
        check("ext_reset_hi", core_reset, 1);
        ext_reset = 1'b0;
        cyc(1);
        check("ext_reset_lo", core_reset, 0);

        // Randomized downloads against the model
        for (int d = 0; d < 3; d++) begin
            ack_delay = $urandom_range(0, 5);
            got.delete();
            exp.delete();
            dl_start(8'h00);
            for (int i = 0; i < 8; i++) begin
                ra = 25'($urandom);
                rd = 8'($urandom);
                exp.push_back(model(ra, rd));
                write_byte(ra, rd, $urandom_range(1, 3), $urandom_range(8, 12));
            end
            ioctl_download = 1'b0;
            wait_loaded($sformatf("rnd%0d_loaded", d));
            compare_q($sformatf("rnd%0d", d), exp);
            check($sformatf("rnd%0d_ovf", d), overflow, 0);
        end
        check("stable_while_waiting", unstable, 0);

        // Reset pulse while a request is outstanding, then a clean restart
        ack_delay = 20;
        got.delete();
        dl_start(8'h00);
        write_byte(25'h400, 8'h33, 1, 1);
        n = 0;
        while (!port_we && n < 20) begin cyc(1); n++; end
        check("mid_in_wait", port_we, 1);
        cyc(2);
        armed = 0;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        check("mid_rst_ports", {port_req, port_we, port_a, port_ds, port_d}, 0);
        check("mid_rst_flags", {busy, overflow, rom_loaded, core_reset}, 4'b0001);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        check("mid_resync", port_req, port_ack);
        check("mid_idle", busy, 0);
        armed = 1;
        cyc(1);
        ack_delay = 2;
        got.delete();
        dl_start(8'h00);
        write_byte(25'h401, 8'h44, 2, 2);
        wait_idle("mid_drain");
        exp.delete();
        exp.push_back(model(25'h401, 8'h44));
        compare_q("mid_write", exp);
        ioctl_download = 1'b0;
        wait_loaded("mid_loaded");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
